fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter for the async FIFO. It shares the FIFO write port among NUM_REQ requesters in the write clock domain, holds a grant for a whole packet or until a burst limit is reached, and throttles on the FIFO `full`/`afull` flags. It sits directly in front of the FIFO write interface (`wr_en`, `wr_data`, `full`, `afull`).

## Interface
- `NUM_REQ`, default 4: number of requesters, at least 2.
- `DATA_WIDTH`, default 4: FIFO data width.
- `MAX_BURST`, default 8: maximum beats per grant, at least 1.
- `clk`, input, 1: write-domain clock; all logic runs on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, NUM_REQ: per-requester beat valid.
- `req_data`, input, NUM_REQ*DATA_WIDTH: packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_last`, input, NUM_REQ: the current beat is the last beat of the packet.
- `req_ready`, output, NUM_REQ: per-requester accept; one-hot or zero.
- `fifo_wr_en`, output, 1: drives the FIFO `wr_en`.
- `fifo_wr_data`, output, DATA_WIDTH: drives the FIFO `wr_data`.
- `fifo_full`, input, 1: FIFO `full`.
- `fifo_afull`, input, 1: FIFO `afull`.
- `grant_id`, output, $clog2(NUM_REQ): index of the current owner; valid while `busy`.
- `busy`, output, 1: the FIFO write port is owned by a requester.

## Operation
- FSM states:
  - IDLE: no owner.
  - XFER: one requester owns the port.
- IDLE -> XFER when `|req` is high and `fifo_afull` is low.
  - Winner: the first requester with `req` high, searching from `rr_ptr+1` modulo NUM_REQ upward.
  - Registers: `grant_id` is set to the winner, `rr_ptr` is set to the winner, and `beat_cnt` is cleared to 0.
- In IDLE, a high `fifo_afull` suppresses new grants.
- In XFER:
  - `req_ready[grant_id] = ~fifo_full`. All other ready bits are 0.
  - A beat is accepted when `req[grant_id] & req_ready[grant_id]`.
  - `fifo_wr_en` is high exactly on accepted beats.
  - `fifo_wr_data` is the `req_data` slice of `grant_id` (combinational mux). It must be 0 when `fifo_wr_en` is low.
  - Each accepted beat increments `beat_cnt` (width $clog2(MAX_BURST+1)).
- XFER -> IDLE on any of the following:
  - an accepted beat with `req_last[grant_id]` high;
  - an accepted beat that makes `beat_cnt` equal MAX_BURST;
  - `req[grant_id]` low in XFER. The requester is released and no beat is written.
- `fifo_afull` has no effect in XFER; only `fifo_full` stalls beats. A stalled beat holds the grant indefinitely.
- `req_last` is ignored on non-accepted cycles.
- A burst-limit release mid-packet lets the same requester re-arbitrate. It wins again only when no other requester is pending, which gives fairness.
- `rr_ptr` resets to NUM_REQ-1, so requester 0 has first priority after reset.
- Reset mid-transfer: the next state is IDLE and all outputs go low on the next cycle. A partially written packet is not rolled back; recovery is the requester's concern.

## Timing
- Reset values: state IDLE, `busy`=0, `grant_id`=0, `rr_ptr`=NUM_REQ-1, `beat_cnt`=0, `req_ready`=0, `fifo_wr_en`=0, `fifo_wr_data`=0.
- Arbitration latency: a request first seen in IDLE at cycle t gives `busy`=1 and `req_ready` at cycle t+1. The first beat can be written at t+1.
- In XFER, data is zero-latency pass-through: a beat is written in the same cycle its requester sees ready.
- Release costs exactly one IDLE bubble cycle between grants.
- `busy` and `grant_id` are registered. `req_ready`, `fifo_wr_en` and `fifo_wr_data` are combinational from the registered state, `req` and `fifo_full`.
- Throughput: MAX_BURST beats per MAX_BURST+1 cycles when requests are continuous and the FIFO is not full.

## Test plan
- Reset, then requester 1 alone sends 3 beats with last on beat 3, FIFO empty:
  - grant at cycle 1;
  - `fifo_wr_en` high for 3 consecutive cycles carrying req1 data;
  - `busy` low on the following cycle.
- Requesters 0–3 all request continuously, 2-beat packets:
  - grant order is 0,1,2,3,0;
  - one idle cycle between packets;
  - no `req_ready` is ever multi-hot.
- Requester 2 sends a 20-beat packet with MAX_BURST=8 and requester 0 is pending:
  - req2 writes 8 beats, then req0 is granted;
  - req2 resumes after req0's packet;
  - the total of written beats equals 20 in order.
- `fifo_full` asserted for 4 cycles mid-packet:
  - `req_ready` and `fifo_wr_en` are low during those cycles;
  - the grant is held and `beat_cnt` is frozen;
  - transfer resumes without data loss.
- `fifo_afull` high in IDLE with pending requests:
  - no grant while it is high;
  - grant on the cycle after `fifo_afull` falls.
- `rst` pulsed during beat 2 of a 4-beat packet:
  - the next cycle has `busy`=0 and `fifo_wr_en`=0;
  - the next grant goes to requester 0 if it is requesting.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester, FIFO write-port and status signals around the write arbiter.
// Latency: none (wires only).
// Backpressure: req_ready per requester, fifo_full/fifo_afull from the FIFO.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4
);
  localparam int GID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_full;
  logic                          fifo_afull;
  logic [GID_W-1:0]              grant_id;
  logic                          busy;

  // master: the arbiter, which owns and drives the FIFO write port
  modport master (
    input  req, req_data, req_last, fifo_full, fifo_afull,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

  // slave: requesters plus FIFO, as seen from outside the arbiter
  modport slave (
    output req, req_data, req_last, fifo_full, fifo_afull,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port, grant held per packet or burst limit.
// Latency: grant one cycle after request in IDLE; data zero-latency pass-through in XFER.
// Backpressure: fifo_full stalls beats (grant held); fifo_afull blocks new grants only.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 8
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int GID_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [GID_W-1:0]   grant_q;
  logic [GID_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]   beat_cnt_q;

  logic               win_vld;
  logic [GID_W-1:0]   win_id;
  logic [GID_W-1:0]   idx;
  logic               accept;
  logic               last_beat;
  logic [NUM_REQ-1:0] ready;
  logic               wr_en;
  logic [DATA_WIDTH-1:0] wr_data;

  // Round-robin search starting just above rr_ptr; the loop runs farthest-first so
  // the nearest pending requester is the one left in win_id.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = GID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (bus.req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  // The beat accepted now is the one that fills the burst allowance.
  assign last_beat = (beat_cnt_q == CNT_W'(MAX_BURST - 1));

  // Next state plus combinational handshake; data is zeroed whenever nothing is written.
  always_comb begin
    state_d = state_q;
    ready   = '0;
    accept  = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    case (state_q)
      IDLE: begin
        if (win_vld && !bus.fifo_afull) begin
          state_d = XFER;
        end
      end
      XFER: begin
        ready[grant_q] = ~bus.fifo_full;
        accept         = bus.req[grant_q] & ~bus.fifo_full;
        if (accept) begin
          wr_en   = 1'b1;
          wr_data = bus.req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        end
        // Owner dropping req releases without a write; req_last only counts on accepted beats.
        if (!bus.req[grant_q] || (accept && (bus.req_last[grant_q] || last_beat))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, owner, round-robin pointer and burst counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= GID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == XFER) begin
        grant_q    <= win_id;
        rr_ptr_q   <= win_id;
        beat_cnt_q <= '0;
      end else if (accept) begin
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.busy         = (state_q == XFER);
  assign bus.grant_id     = grant_q;
  assign bus.req_ready    = ready;
  assign bus.fifo_wr_en   = wr_en;
  assign bus.fifo_wr_data = wr_data;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus traffic sequences.
// Latency: checks grant one cycle after request and one bubble between grants.
// Backpressure: exercises fifo_full stalls mid-packet and fifo_afull gating in IDLE.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 4;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [15:0] data;
    logic [3:0] last;
    logic       full;
    logic       afull;
    logic       busy;
    logic [1:0] gid;
    logic [3:0] rdy;
    logic       wr;
    logic [3:0] wdat;
  } vec_t;

  vec_t vecs[$];

  // traffic source description
  int         pkt_len[NR];
  int         pkt_start[NR];
  logic [3:0] pkt_base[NR];
  int         full_from;
  int         full_cnt;
  int         log_id[$];
  int         log_dat[$];
  int         log_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [15:0] d,
                     input logic [3:0] l, input logic f, input logic af,
                     input logic b, input logic [1:0] g, input logic [3:0] rd,
                     input logic w, input logic [3:0] wd);
    vec_t v;
    v.rst = r;  v.req = rq; v.data = d;  v.last = l; v.full = f; v.afull = af;
    v.busy = b; v.gid = g;  v.rdy = rd;  v.wr = w;   v.wdat = wd;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req = '0; bus.req_last = '0; bus.req_data = '0;
    bus.fifo_full = 1'b0; bus.fifo_afull = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Requester i sends pkt_len[i] beats from cycle pkt_start[i]; data = pkt_base[i] + beat index.
  task automatic run_traffic(input string tag, input int max_cycles);
    int          sent[NR];
    bit          done;
    logic [15:0] d;
    logic [3:0]  rq;
    logic [3:0]  lst;
    sent = '{default: 0};
    done = 1'b0;
    log_id.delete(); log_dat.delete(); log_cyc.delete();
    for (int cyc = 0; cyc < max_cycles && !done; cyc++) begin
      @(negedge clk);
      rq = '0; lst = '0; d = '0;
      for (int i = 0; i < NR; i++) begin
        d[i*DW +: DW] = pkt_base[i] + 4'(sent[i]);
        if (cyc >= pkt_start[i] && sent[i] < pkt_len[i]) begin
          rq[i]  = 1'b1;
          lst[i] = (sent[i] == pkt_len[i] - 1);
        end
      end
      bus.req = rq; bus.req_data = d; bus.req_last = lst;
      bus.fifo_full = (cyc >= full_from && cyc < full_from + full_cnt);
      #1;
      check({tag, "_onehot_rdy"}, 32'($onehot0(bus.req_ready)), 32'd1);
      if (bus.fifo_full) begin
        check({tag, "_stall_rdy"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_stall_wr"}, 32'(bus.fifo_wr_en), 32'd0);
        check({tag, "_stall_busy"}, 32'(bus.busy), 32'd1);
      end
      if (bus.fifo_wr_en) begin
        log_id.push_back(int'(bus.grant_id));
        log_dat.push_back(int'(bus.fifo_wr_data));
        log_cyc.push_back(cyc);
      end
      for (int i = 0; i < NR; i++) begin
        if (rq[i] && bus.req_ready[i]) sent[i]++;
      end
      done = 1'b1;
      for (int i = 0; i < NR; i++) begin
        if (sent[i] < pkt_len[i]) done = 1'b0;
      end
    end
    check({tag, "_completed"}, 32'(done), 32'd1);
    @(negedge clk);
    bus.req = '0; bus.req_last = '0; bus.fifo_full = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_id[$];
    int exp_dat[$];

    // Single requester 1, 3 beats, last on beat 3
    add(0, 4'b0010, 16'hA05A, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
    add(0, 4'b0010, 16'hA05A, 4'b0000, 0, 0,  1, 2'd1, 4'b0010, 1, 4'h5);
    add(0, 4'b0010, 16'hA06A, 4'b0000, 0, 0,  1, 2'd1, 4'b0010, 1, 4'h6);
    add(0, 4'b0010, 16'hA07A, 4'b0010, 0, 0,  1, 2'd1, 4'b0010, 1, 4'h7);
    add(0, 4'b0000, 16'h0000, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
    // Reset, then all four request continuously with 2-beat packets: order 0,1,2,3,0
    add(1, 4'b0000, 16'h0000, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
    add(0, 4'b1111, 16'h4321, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
    add(0, 4'b1111, 16'h4321, 4'b0000, 0, 0,  1, 2'd0, 4'b0001, 1, 4'h1);
    add(0, 4'b1111, 16'h4321, 4'b1111, 0, 0,  1, 2'd0, 4'b0001, 1, 4'h1);
    add(0, 4'b1111, 16'h4321, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
    add(0, 4'b1111, 16'h4321, 4'b0000, 0, 0,  1, 2'd1, 4'b0010, 1, 4'h2);
    add(0, 4'b1111, 16'h4321, 4'b1111, 0, 0,  1, 2'd1, 4'b0010, 1, 4'h2);
    add(0, 4'b1111, 16'h4321, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
    add(0, 4'b1111, 16'h4321, 4'b0000, 0, 0,  1, 2'd2, 4'b0100, 1, 4'h3);
    add(0, 4'b1111, 16'h4321, 4'b1111, 0, 0,  1, 2'd2, 4'b0100, 1, 4'h3);
    add(0, 4'b1111, 16'h4321, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
    add(0, 4'b1111, 16'h4321, 4'b0000, 0, 0,  1, 2'd3, 4'b1000, 1, 4'h4);
    add(0, 4'b1111, 16'h4321, 4'b1111, 0, 0,  1, 2'd3, 4'b1000, 1, 4'h4);
    add(0, 4'b1111, 16'h4321, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
    add(0, 4'b1111, 16'h4321, 4'b0000, 0, 0,  1, 2'd0, 4'b0001, 1, 4'h1);
    add(0, 4'b1111, 16'h4321, 4'b1111, 0, 0,  1, 2'd0, 4'b0001, 1, 4'h1);
    add(0, 4'b0000, 16'h4321, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
    // afull blocks grant in IDLE; grant the cycle after it falls; afull ignored in XFER
    add(0, 4'b0100, 16'h4321, 4'b0000, 0, 1,  0, 2'd0, 4'b0000, 0, 4'h0);
    add(0, 4'b0100, 16'h4321, 4'b0000, 0, 1,  0, 2'd0, 4'b0000, 0, 4'h0);
    add(0, 4'b0100, 16'h4321, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
    add(0, 4'b0100, 16'h4321, 4'b0100, 0, 1,  1, 2'd2, 4'b0100, 1, 4'h3);
    add(0, 4'b0000, 16'h0000, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
    // rst during beat 2 of requester 0's packet; pointer must return so 0 beats 1
    add(0, 4'b0001, 16'h0007, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
    add(0, 4'b0001, 16'h0007, 4'b0000, 0, 0,  1, 2'd0, 4'b0001, 1, 4'h7);
    add(1, 4'b0001, 16'h0008, 4'b0000, 0, 0,  1, 2'd0, 4'b0001, 1, 4'h8);
    add(0, 4'b0011, 16'h0059, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);
    add(0, 4'b0011, 16'h0059, 4'b0001, 0, 0,  1, 2'd0, 4'b0001, 1, 4'h9);
    add(0, 4'b0000, 16'h0000, 4'b0000, 0, 0,  0, 2'd0, 4'b0000, 0, 4'h0);

    rst = 1'b1;
    bus.req = '0; bus.req_data = '0; bus.req_last = '0;
    bus.fifo_full = 1'b0; bus.fifo_afull = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_gid", 32'(bus.grant_id), 32'd0);
    check("reset_rdy", 32'(bus.req_ready), 32'd0);
    check("reset_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    check("reset_wr_data", 32'(bus.fifo_wr_data), 32'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rst = vecs[k].rst;
      bus.req = vecs[k].req;         bus.req_data = vecs[k].data;
      bus.req_last = vecs[k].last;   bus.fifo_full = vecs[k].full;
      bus.fifo_afull = vecs[k].afull;
      #1;
      check($sformatf("vec%0d_busy", k), 32'(bus.busy), 32'(vecs[k].busy));
      if (vecs[k].busy) check($sformatf("vec%0d_gid", k), 32'(bus.grant_id), 32'(vecs[k].gid));
      check($sformatf("vec%0d_rdy", k), 32'(bus.req_ready), 32'(vecs[k].rdy));
      check($sformatf("vec%0d_wr_en", k), 32'(bus.fifo_wr_en), 32'(vecs[k].wr));
      check($sformatf("vec%0d_wr_data", k), 32'(bus.fifo_wr_data), 32'(vecs[k].wdat));
    end

    // 20-beat packet on req2 split by the 8-beat limit, req0 pending with 2 beats
    do_reset();
    pkt_len   = '{2, 0, 20, 0};
    pkt_start = '{2, 0, 0, 0};
    pkt_base  = '{4'hA, 4'h0, 4'h0, 4'h0};
    full_from = 0; full_cnt = 0;
    run_traffic("burst", 200);
    for (int i = 0; i < 8; i++) begin exp_id.push_back(2); exp_dat.push_back(i); end
    exp_id.push_back(0); exp_dat.push_back(10);
    exp_id.push_back(0); exp_dat.push_back(11);
    for (int i = 8; i < 20; i++) begin exp_id.push_back(2); exp_dat.push_back(i % 16); end
    check("burst_count", 32'(log_id.size()), 32'(exp_id.size()));
    for (int k = 0; k < exp_id.size() && k < log_id.size(); k++) begin
      check($sformatf("burst_id%0d", k), 32'(log_id[k]), 32'(exp_id[k]));
      check($sformatf("burst_dat%0d", k), 32'(log_dat[k]), 32'(exp_dat[k]));
    end
    if (log_cyc.size() >= 11) begin
      check("burst_bubble_after_limit", 32'(log_cyc[8] - log_cyc[7]), 32'd2);
      check("burst_bubble_after_req0", 32'(log_cyc[10] - log_cyc[9]), 32'd2);
    end

    // fifo_full for 4 cycles after beat 2 of a 10-beat packet on req1
    do_reset();
    pkt_len   = '{0, 10, 0, 0};
    pkt_start = '{0, 0, 0, 0};
    pkt_base  = '{4'h0, 4'h0, 4'h0, 4'h0};
    full_from = 3; full_cnt = 4;
    run_traffic("stall", 200);
    check("stall_count", 32'(log_id.size()), 32'd10);
    for (int k = 0; k < log_id.size(); k++) begin
      check($sformatf("stall_id%0d", k), 32'(log_id[k]), 32'd1);
      check($sformatf("stall_dat%0d", k), 32'(log_dat[k]), 32'(k));
    end
    if (log_cyc.size() >= 9) begin
      check("stall_first_beat_cycle", 32'(log_cyc[0]), 32'd1);
      check("stall_gap", 32'(log_cyc[2] - log_cyc[1]), 32'd5);
      check("stall_limit_after_8", 32'(log_cyc[8] - log_cyc[7]), 32'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
